generador_pasos: RTL and testbench

- Upstream step source for the dance game's value-adjust stage. During a song it generates one pseudo-random raw 3-bit step code per beat.
- Codes come from an 8-bit LFSR. Each code is presented on a valid/ready handshake to the stage that folds raw codes into arrow codes (0,1,2,4).
- Paces the song by a beat divider and stops after a fixed number of steps.

---
 rtl/generador_pasos.sv | 117 +++++++++++
 tb/tb_generador_pasos.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/generador_pasos.sv
// Beat-paced step generator: one pseudo-random 3-bit code per beat from an 8-bit LFSR,
// offered on a valid/ready handshake until the song's step count is reached.
module generador_pasos #(
   parameter int unsigned BEAT_DIV = 50_000_000,
   parameter int unsigned STEPS    = 32,
   parameter logic [7:0]  SEED     = 8'h01
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         enable,
   input  logic                         step_ready,
   output logic                         step_valid,
   output logic [2:0]                   step_data,
   output logic [$clog2(STEPS+1)-1:0]   steps_issued,
   output logic                         overrun,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned CntW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam int unsigned IssW = $clog2(STEPS + 1);
   localparam logic [CntW-1:0] CntMax   = CntW'(BEAT_DIV - 1);
   localparam logic [IssW-1:0] LastStep = IssW'(STEPS - 1);
   // An all-zero LFSR would lock up, so a zero seed is swapped for a fixed non-zero value.
   localparam logic [7:0]      SeedEff  = (SEED == 8'h00) ? 8'hA5 : SEED;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [7:0]        lfsr_q, lfsr_d;
   logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
   logic              step_valid_q, step_valid_d;
   logic [2:0]        step_data_q, step_data_d;
   logic [IssW-1:0]   issued_q, issued_d;
   logic              overrun_q, overrun_d;

   logic              tick;
   logic [7:0]        lfsr_next;

   assign tick      = (state_q == StRun) && enable && (beat_cnt_q == CntMax);
   assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      beat_cnt_d   = beat_cnt_q;
      step_data_d  = step_data_q;
      issued_d     = issued_q;
      overrun_d    = overrun_q;
      step_valid_d = step_valid_q & ~step_ready;

      if (state_q == StRun && enable) begin
         beat_cnt_d = tick ? '0 : beat_cnt_q + 1'b1;
      end

      if (tick) begin
         lfsr_d       = lfsr_next;
         step_data_d  = lfsr_next[2:0];
         step_valid_d = 1'b1;
         // A tick on an unaccepted step loses it; a same-cycle accept is not a loss.
         if (step_valid_q && !step_ready) begin
            overrun_d = 1'b1;
         end
         if (issued_q != IssW'(STEPS)) begin
            issued_d = issued_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StRun;
               lfsr_d       = SeedEff;
               beat_cnt_d   = '0;
               issued_d     = '0;
               overrun_d    = 1'b0;
               step_valid_d = 1'b0;
            end
         end
         StRun: begin
            if (tick && issued_q == LastStep) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         lfsr_q       <= SeedEff;
         beat_cnt_q   <= '0;
         step_valid_q <= 1'b0;
         step_data_q  <= '0;
         issued_q     <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         beat_cnt_q   <= beat_cnt_d;
         step_valid_q <= step_valid_d;
         step_data_q  <= step_data_d;
         issued_q     <= issued_d;
         overrun_q    <= overrun_d;
      end
   end

   assign step_valid   = step_valid_q;
   assign step_data    = step_data_q;
   assign steps_issued = issued_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q == StRun);
   assign done         = (state_q == StDone) && !step_valid_q;

endmodule

// File: tb/tb_generador_pasos.sv
// Scoreboard bench for generador_pasos: directed songs push expected (code, cycle) pairs,
// a monitor pops them on each handshake transfer.
module tb_generador_pasos;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic enable = 1'b1;
   logic step_ready = 1'b0;
   logic step_valid;
   logic [2:0] step_data;
   logic [2:0] steps_issued;
   logic overrun, busy, done;

   logic z_start = 1'b0;
   logic z_ready = 1'b1;
   logic z_valid;
   logic [2:0] z_data;
   logic [7:0] z_issued;
   logic z_overrun, z_busy, z_done;

   generador_pasos #(.BEAT_DIV(4), .STEPS(4), .SEED(8'h01)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .step_ready(step_ready),
      .step_valid(step_valid), .step_data(step_data), .steps_issued(steps_issued),
      .overrun(overrun), .busy(busy), .done(done)
   );

   generador_pasos #(.BEAT_DIV(2), .STEPS(255), .SEED(8'h00)) dut_z (
      .clk(clk), .rst_n(rst_n), .start(z_start), .enable(enable), .step_ready(z_ready),
      .step_valid(z_valid), .step_data(z_data), .steps_issued(z_issued),
      .overrun(z_overrun), .busy(z_busy), .done(z_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {int data; int cyc;} exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   int seq[4] = '{2, 4, 0, 1};
   logic [7:0] zm = 8'hA5;
   int z_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic start_song(output int s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      s = cyc;
   endtask

   // Inputs settle at the negedge; sampling 1 time unit later sees what the next posedge uses.
   always @(negedge clk) begin
      #1;
      if (rst_n && step_valid && step_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_transfer: got code %0d at cycle %0d, expected none",
                     step_data, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("step_data", step_data, mon_e.data);
            chk("step_cycle", cyc, mon_e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst_n && z_valid) begin
         zm = {zm[6:0], zm[7] ^ zm[5] ^ zm[4] ^ zm[3]};
         chk("zero_seed_seq", z_data, zm[2:0]);
         z_seen++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int gap;
      int t;

      repeat (3) @(negedge clk);
      chk("reset_valid", step_valid, 0);
      chk("reset_data", step_data, 0);
      chk("reset_issued", steps_issued, 0);
      chk("reset_overrun", overrun, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic sequence, always ready
      step_ready = 1'b1;
      start_song(s);
      for (int k = 0; k < 4; k++) push(seq[k], s + 4 + 4 * k);
      wait_to(s + 17);
      chk("seq_done", done, 1);
      chk("seq_busy", busy, 0);
      chk("seq_issued", steps_issued, 4);
      chk("seq_valid", step_valid, 0);
      chk("seq_sb_empty", sb_q.size(), 0);

      // Ready only in tick cycles: each transfer coincides with the next load
      step_ready = 1'b0;
      start_song(s);
      push(2, s + 7);
      push(4, s + 11);
      push(0, s + 15);
      push(1, s + 18);
      gap = 0;
      while (cyc < s + 19) begin
         t = cyc - s;
         step_ready = (t == 3 || t == 7 || t == 11 || t == 15 || t == 18);
         if (t >= 4 && !step_valid) gap++;
         @(negedge clk);
      end
      step_ready = 1'b0;
      chk("tick_accept_gap", gap, 0);
      chk("tick_accept_overrun", overrun, 0);
      chk("tick_accept_done", done, 1);

      // Overrun with no acceptance at all
      start_song(s);
      wait_to(s + 5);
      chk("ovr_first_valid", step_valid, 1);
      chk("ovr_first_data", step_data, 2);
      chk("ovr_first_flag", overrun, 0);
      wait_to(s + 8);
      chk("ovr_second_data", step_data, 4);
      chk("ovr_second_flag", overrun, 1);
      chk("ovr_second_issued", steps_issued, 2);
      wait_to(s + 20);
      chk("ovr_sticky", overrun, 1);
      chk("ovr_pending_valid", step_valid, 1);
      chk("ovr_pending_data", step_data, 1);
      chk("ovr_pending_done", done, 0);
      chk("ovr_pending_busy", busy, 0);

      // Restart from DONE with a pending step, then pause mid-beat
      start_song(s);
      chk("restart_valid", step_valid, 0);
      chk("restart_overrun", overrun, 0);
      chk("restart_busy", busy, 1);
      chk("restart_issued", steps_issued, 0);
      step_ready = 1'b1;
      for (int k = 0; k < 4; k++) push(seq[k], s + 14 + 4 * k);
      @(negedge clk);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      chk("pause_valid", step_valid, 0);
      chk("pause_busy", busy, 1);
      enable = 1'b1;
      wait_to(s + 27);
      chk("pause_done", done, 1);
      chk("pause_issued", steps_issued, 4);

      // Reset while a step is pending, then replay
      step_ready = 1'b0;
      start_song(s);
      wait_to(s + 5);
      chk("prerst_valid", step_valid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_valid", step_valid, 0);
      chk("rst_data", step_data, 0);
      chk("rst_issued", steps_issued, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      step_ready = 1'b1;
      @(negedge clk);
      start_song(s);
      for (int k = 0; k < 4; k++) push(seq[k], s + 4 + 4 * k);
      wait_to(s + 17);
      chk("replay_done", done, 1);
      chk("replay_sb_empty", sb_q.size(), 0);

      // Zero seed, full 255-step song
      z_start = 1'b1;
      @(negedge clk);
      z_start = 1'b0;
      t = 0;
      while (!z_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("zero_first_valid", z_valid, 1);
      chk("zero_first_data", z_data, 2);
      t = 0;
      while (!z_done && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("zero_done", z_done, 1);
      chk("zero_issued", z_issued, 255);
      chk("zero_seen", z_seen, 255);
      chk("zero_overrun", z_overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
